alu_4bit: RTL and testbench
===========================

ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: data 4 bits, opcode 3 bits.
REQ-002 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port a, input, 4: operand A, unsigned / two's complement per operation.
REQ-005 Port b, input, 4: operand B; for shifts only b[1:0] is used as the shift amount.
REQ-006 Port s, input, 3: operation select.
REQ-007 Port in_valid, input, 1: a, b and s are sampled on a rising clk edge only when in_valid=1.
REQ-008 Port y, output, 4: registered result.
REQ-009 Port flag_c, output, 1: registered carry / borrow / shift-out flag.
REQ-010 Port flag_v, output, 1: registered signed-overflow flag.
REQ-011 Port flag_z, output, 1: registered zero flag; equals 1 when y=0000.
REQ-012 Port flag_n, output, 1: registered negative flag; equals y[3].
REQ-013 Port out_valid, output, 1: equals 1 for exactly the cycle after each accepted operation.

Function
REQ-014 Opcodes SHALL be: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 NOT a (b ignored); 101 XOR; 110 SHL a by b[1:0]; 111 SHR (logical) a by b[1:0].
REQ-015 ADD: y=(a+b) mod 16; flag_c=carry out of bit 3; flag_v=1 when a[3]=b[3] and y[3]!=a[3].
REQ-016 SUB: y=(a-b) mod 16; flag_c=1 (borrow) when a<b unsigned; flag_v=1 when a[3]!=b[3] and y[3]!=a[3].
REQ-017 SHL/SHR: zeros are shifted in; flag_c is the last bit shifted out; flag_c=0 when the shift amount is 0.
REQ-018 For AND, OR, NOT and XOR, flag_c=0 and flag_v=0; for SHL and SHR, flag_v=0.
REQ-019 Latency SHALL be 1 cycle: inputs accepted at edge k appear on y/flags after edge k, with out_valid=1 until edge k+1.
REQ-020 When in_valid=0 at an edge, y and all flags SHALL hold their previous values and out_valid SHALL be 0.
REQ-021 Back-to-back operations, with in_valid high on every cycle, SHALL be accepted every cycle with no bubbles.
REQ-022 The computation SHALL be fully combinational ahead of one output register stage, with no internal multi-cycle state.

Reset
REQ-023 While rst=1, y SHALL be 0000, flag_c, flag_v and flag_n SHALL be 0, flag_z SHALL be 1 and out_valid SHALL be 0, immediately and without waiting for a clock edge.
REQ-024 An operation in flight when rst asserts SHALL be discarded; the first operation accepted after reset is the first edge at which rst=0 and in_valid=1.

Verification
REQ-025 ADD a=1000 b=0110, then SUB a=0110 b=1010 -> y=1110 c=0 v=0 n=1; then y=1100 c=1 v=1 n=1.
REQ-026 AND a=1001 b=0011 -> 0001; OR a=1100 b=0111 -> 1111; NOT a=0011 -> 1100; XOR a=1010 b=1111 -> 0101; each with c=0 v=0.
REQ-027 SHL a=1100 b=0110 -> y=0000 z=1 c=1; SHR a=0111 b=0010 -> y=0001 c=1.
REQ-028 Overflow/zero: ADD 0111+0001 -> 1000 v=1 n=1; ADD 1111+0001 -> 0000 c=1 z=1.
REQ-029 Handshake: in_valid=0 for 3 cycles after an ADD -> y holds and out_valid=0; consecutive in_valid=1 cycles -> a result every cycle.
REQ-030 Reset: assert rst mid-cycle during back-to-back traffic -> y=0000, z=1, out_valid=0 before the next edge; normal results resume after release.

Source files
------------

// File: rtl/alu_4bit.sv
// 4-bit ALU (add/sub/logic/shift) with registered result and NZCV-style flags.
// Latency 1 cycle; in_valid is accepted every cycle, there is no backpressure.
module alu_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] s,
    input  logic       in_valid,
    output logic [3:0] y,
    output logic       flag_c,
    output logic       flag_v,
    output logic       flag_z,
    output logic       flag_n,
    output logic       out_valid
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [4:0] arith_w;
    logic [4:0] shl_w;
    logic [4:0] shr_w;
    logic [3:0] res_y;
    logic       res_c;
    logic       res_v;

    logic [3:0] y_d, y_q;
    logic       c_d, c_q;
    logic       v_d, v_q;
    logic       z_d, z_q;
    logic       n_d, n_q;
    logic       out_valid_d, out_valid_q;

    // Shifts carry one guard bit so the last bit shifted out lands in a fixed
    // position; a zero shift amount leaves that guard bit at 0.
    always_comb begin
        arith_w = '0;
        shl_w   = {1'b0, a} << b[1:0];
        shr_w   = {a, 1'b0} >> b[1:0];
        res_y   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (s)
            OP_ADD: begin
                arith_w = {1'b0, a} + {1'b0, b};
                res_y   = arith_w[3:0];
                res_c   = arith_w[4];
                res_v   = (a[3] == b[3]) && (res_y[3] != a[3]);
            end
            OP_SUB: begin
                arith_w = {1'b0, a} - {1'b0, b};
                res_y   = arith_w[3:0];
                res_c   = arith_w[4];
                res_v   = (a[3] != b[3]) && (res_y[3] != a[3]);
            end
            OP_AND: res_y = a & b;
            OP_OR:  res_y = a | b;
            OP_NOT: res_y = ~a;
            OP_XOR: res_y = a ^ b;
            OP_SHL: begin
                res_y = shl_w[3:0];
                res_c = shl_w[4];
            end
            OP_SHR: begin
                res_y = shr_w[4:1];
                res_c = shr_w[0];
            end
        endcase
    end

    always_comb begin
        out_valid_d = in_valid;
        y_d         = y_q;
        c_d         = c_q;
        v_d         = v_q;
        z_d         = z_q;
        n_d         = n_q;
        if (in_valid) begin
            y_d = res_y;
            c_d = res_c;
            v_d = res_v;
            z_d = (res_y == 4'b0000);
            n_d = res_y[3];
        end
    end

    // Reset presents a zero result, so the zero flag comes up set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q         <= 4'b0000;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b1;
            n_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            c_q         <= c_d;
            v_q         <= v_d;
            z_q         <= z_d;
            n_q         <= n_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Randomised and directed bench for alu_4bit against an integer-arithmetic model.
module tb_alu_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic       in_valid;
    logic [3:0] y;
    logic       flag_c, flag_v, flag_z, flag_n, out_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Expected registered state: {y, c, v, z, n}
    logic [7:0] exp_q;

    alu_4bit dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .s(s), .in_valid(in_valid),
        .y(y), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
        .flag_n(flag_n), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference model from the arithmetic definitions; returns {y, c, v, z, n}.
    function automatic logic [7:0] model(input int ai, input int bi, input int op);
        int r, c, v, sa, sb, sr, n;
        sa = (ai >= 8) ? ai - 16 : ai;
        sb = (bi >= 8) ? bi - 16 : bi;
        n  = bi % 4;
        c  = 0;
        v  = 0;
        case (op)
            0: begin r = ai + bi; c = (r > 15); sr = sa + sb; v = (sr > 7 || sr < -8); end
            1: begin r = ai - bi; c = (ai < bi); sr = sa - sb; v = (sr > 7 || sr < -8); end
            2: r = ai & bi;
            3: r = ai | bi;
            4: r = 15 - ai;
            5: r = ai ^ bi;
            6: begin r = ai * (1 << n); c = (n == 0) ? 0 : ((r / 16) % 2); end
            default: begin r = ai / (1 << n); c = (n == 0) ? 0 : ((ai / (1 << (n - 1))) % 2); end
        endcase
        r = ((r % 16) + 16) % 16;
        model = {r[3:0], c[0], v[0], (r == 0), (r >= 8)};
    endfunction

    task automatic drive(input logic [3:0] ai, input logic [3:0] bi, input logic [2:0] op, input logic vld);
        @(negedge clk);
        a = ai; b = bi; s = op; in_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; s = '0;
        #3;
        n_cmp++;
        if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== 9'b0000_0_0_1_0_0) begin
            n_err++;
            $display("FAIL reset_state got=%b want=%b", {y, flag_c, flag_v, flag_z, flag_n, out_valid}, 9'b000000100);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q = 8'b0000_0_0_1_0;
    endtask

    task automatic test_directed;
        logic [3:0] ta [12] = '{4'b1000, 4'b0110, 4'b1001, 4'b1100, 4'b0011, 4'b1010,
                                 4'b1100, 4'b0111, 4'b0111, 4'b1111, 4'b0101, 4'b1001};
        logic [3:0] tb [12] = '{4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b0000, 4'b1111,
                                 4'b0110, 4'b0010, 4'b0001, 4'b0001, 4'b0100, 4'b0000};
        logic [2:0] ts [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd6, 3'd7};
        // Expected {y, c, v, z, n} taken from the worked examples.
        logic [7:0] te [12] = '{8'b1110_0_0_0_1, 8'b1100_1_1_0_1, 8'b0001_0_0_0_0, 8'b1111_0_0_0_1,
                                 8'b1100_0_0_0_1, 8'b0101_0_0_0_0, 8'b0000_1_0_1_0, 8'b0001_1_0_0_0,
                                 8'b1000_0_1_0_1, 8'b0000_1_0_1_0, 8'b0101_0_0_0_0, 8'b1001_0_0_0_1};
        for (int i = 0; i < 12; i++) begin
            drive(ta[i], tb[i], ts[i], 1'b1);
            n_cmp++;
            if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== {te[i], 1'b1}) begin
                n_err++;
                $display("FAIL directed[%0d] got=%b want=%b", i, {y, flag_c, flag_v, flag_z, flag_n, out_valid}, {te[i], 1'b1});
            end
            exp_q = te[i];
        end
    endtask

    task automatic test_handshake;
        drive(4'b0011, 4'b0100, 3'd0, 1'b1);
        exp_q = 8'b0111_0_0_0_0;
        n_cmp++;
        if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== {exp_q, 1'b1}) begin
            n_err++;
            $display("FAIL hs_add got=%b want=%b", {y, flag_c, flag_v, flag_z, flag_n, out_valid}, {exp_q, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom), 4'($urandom), 3'($urandom), 1'b0);
            n_cmp++;
            if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== {exp_q, 1'b0}) begin
                n_err++;
                $display("FAIL hs_idle[%0d] got=%b want=%b", i, {y, flag_c, flag_v, flag_z, flag_n, out_valid}, {exp_q, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] ra, rb;
        logic [2:0] rs;
        for (int i = 0; i < 64; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rs = 3'(i % 8);
            drive(ra, rb, rs, 1'b1);
            exp_q = model(int'(ra), int'(rb), int'(rs));
            n_cmp++;
            if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== {exp_q, 1'b1}) begin
                n_err++;
                $display("FAIL b2b[%0d] a=%h b=%h s=%0d got=%b want=%b", i, ra, rb, rs,
                         {y, flag_c, flag_v, flag_z, flag_n, out_valid}, {exp_q, 1'b1});
            end
        end
    endtask

    task automatic test_random;
        logic [3:0] ra, rb;
        logic [2:0] rs;
        logic       rv;
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rs = 3'($urandom);
            rv = ($urandom_range(3, 0) != 0);
            drive(ra, rb, rs, rv);
            if (rv) exp_q = model(int'(ra), int'(rb), int'(rs));
            n_cmp++;
            if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== {exp_q, rv}) begin
                n_err++;
                $display("FAIL random[%0d] a=%h b=%h s=%0d v=%b got=%b want=%b", i, ra, rb, rs, rv,
                         {y, flag_c, flag_v, flag_z, flag_n, out_valid}, {exp_q, rv});
            end
        end
    endtask

    task automatic test_reset_mid;
        drive(4'b0101, 4'b0110, 3'd0, 1'b1);
        drive(4'b1111, 4'b0011, 3'd2, 1'b1);
        // Assert mid-cycle with traffic still valid; outputs must clear before any edge.
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== 9'b0000_0_0_1_0_0) begin
            n_err++;
            $display("FAIL reset_mid got=%b want=%b", {y, flag_c, flag_v, flag_z, flag_n, out_valid}, 9'b000000100);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== 9'b0000_0_0_1_0_0) begin
            n_err++;
            $display("FAIL reset_hold got=%b want=%b", {y, flag_c, flag_v, flag_z, flag_n, out_valid}, 9'b000000100);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q = 8'b0000_0_0_1_0;
        drive(4'b0010, 4'b0011, 3'd0, 1'b1);
        n_cmp++;
        if ({y, flag_c, flag_v, flag_z, flag_n, out_valid} !== 9'b0101_0_0_0_0_1) begin
            n_err++;
            $display("FAIL reset_resume got=%b want=%b", {y, flag_c, flag_v, flag_z, flag_n, out_valid}, 9'b010100001);
        end
        exp_q = 8'b0101_0_0_0_0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        in_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
